// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS write-back / bypass block.
//   REG_ZERO       - hard-wired zero register, never written or forwarded
//   SRC_RF/SRC_FWD - EX operand mux select encodings
//   bypass_slot_t  - contents of one in-flight pipeline slot (M or W)
package mips_pkg;

    localparam int SLOT_DW = 32;
    localparam int SLOT_AW = 5;

    localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

    localparam logic SRC_RF  = 1'b1;
    localparam logic SRC_FWD = 1'b0;

    typedef struct packed {
        logic               vld;
        logic               wen;
        logic [SLOT_AW-1:0] dst;
        logic               is_load;
        logic [SLOT_DW-1:0] data;
    } bypass_slot_t;

endpackage

// File: rtl/mips_bypass_wb_match.sv
// bypass_match: combinational hit detection and forward select for one EX
// source operand.
//   slot_m, slot_w - M and W slot contents
//   src            - source register of the EX operand
//   fwd_data       - forwarded value (0 when no hit)
//   alu_src        - SRC_RF when the register-file read is used
//   load_use       - operand depends on a load still sitting in M
module bypass_match
    import mips_pkg::*;
(
    input  bypass_slot_t       slot_m,
    input  bypass_slot_t       slot_w,
    input  logic [SLOT_AW-1:0] src,
    output logic [SLOT_DW-1:0] fwd_data,
    output logic               alu_src,
    output logic               load_use
);

    logic hit_m;
    logic hit_w;

    // W never carries a pending load (its data is already resolved).
    logic unused_w_is_load;
    assign unused_w_is_load = slot_w.is_load;

    assign hit_m = slot_m.vld & slot_m.wen & (slot_m.dst == src) & (src != REG_ZERO);
    assign hit_w = slot_w.vld & slot_w.wen & (slot_w.dst == src) & (src != REG_ZERO);

    // M is younger than W, so it wins. A load in M has no data yet: the
    // caller stalls and the value picked here is meaningless for that cycle.
    always_comb begin
        fwd_data = '0;
        alu_src  = SRC_RF;
        load_use = 1'b0;
        if (hit_m) begin
            if (slot_m.is_load) begin
                load_use = 1'b1;
            end else begin
                fwd_data = slot_m.data;
                alu_src  = SRC_FWD;
            end
        end else if (hit_w) begin
            fwd_data = slot_w.data;
            alu_src  = SRC_FWD;
        end
    end

endmodule

// File: rtl/mips_bypass_wb.sv
// mips_bypass_wb: MEM/WB result tracking, register-file write port, EX operand
// bypass and load-use stall for a 5-stage MIPS pipeline.
//   clk, rst                  - clock, synchronous active-high reset
//   ex_*                      - instruction currently in EX
//   mem_rdata                 - load data for the instruction in M
//   forward_a/b, alu_src_a/b  - EX operand bypass value and select
//   stall                     - load-use stall (hold EX, freeze front end)
//   rf_we/rf_waddr/rf_wdata   - register-file write port, driven from W
//   stall_cnt                 - saturating count of stall cycles
module mips_bypass_wb
    import mips_pkg::*;
#(
    parameter int DW = SLOT_DW,
    parameter int AW = SLOT_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_wen,
    input  logic [AW-1:0] ex_dst,
    input  logic          ex_is_load,
    input  logic [DW-1:0] ex_result,
    input  logic [AW-1:0] ex_rs,
    input  logic [AW-1:0] ex_rt,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] forward_a,
    output logic [DW-1:0] forward_b,
    output logic          alu_src_a,
    output logic          alu_src_b,
    output logic          stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [31:0]   stall_cnt
);

    localparam int NUM_SRC = 2;

    bypass_slot_t slot_m;
    bypass_slot_t slot_w;

    logic [NUM_SRC-1:0][AW-1:0] src_reg;
    logic [NUM_SRC-1:0][DW-1:0] fwd_val;
    logic [NUM_SRC-1:0]         src_sel;
    logic [NUM_SRC-1:0]         load_use;

    assign src_reg = {ex_rt, ex_rs};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
        bypass_match u_match (
            .slot_m   (slot_m),
            .slot_w   (slot_w),
            .src      (src_reg[i]),
            .fwd_data (fwd_val[i]),
            .alu_src  (src_sel[i]),
            .load_use (load_use[i])
        );
    end

    assign forward_a = fwd_val[0];
    assign forward_b = fwd_val[1];
    assign alu_src_a = src_sel[0];
    assign alu_src_b = src_sel[1];
    assign stall     = |load_use;

    // The stalled EX instruction becomes a bubble in M; upstream re-presents
    // it next cycle, when the load has moved to W and can be forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_m <= '0;
            slot_w <= '0;
        end else begin
            slot_m.vld     <= ex_valid & ~stall;
            slot_m.wen     <= ex_wen;
            slot_m.dst     <= ex_dst;
            slot_m.is_load <= ex_is_load;
            slot_m.data    <= ex_result;

            slot_w      <= slot_m;
            slot_w.data <= slot_m.is_load ? mem_rdata : slot_m.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign rf_we    = slot_w.vld & slot_w.wen & (slot_w.dst != REG_ZERO);
    assign rf_waddr = slot_w.dst;
    assign rf_wdata = slot_w.data;

endmodule

// File: tb/tb_mips_bypass_wb.sv
// tb_mips_bypass_wb: directed steps from the test plan followed by a random
// instruction stream, all checked against an in-flight-write model.
module tb_mips_bypass_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_wen, ex_is_load;
    logic [4:0]  ex_dst, ex_rs, ex_rt;
    logic [31:0] ex_result, mem_rdata;
    logic [31:0] forward_a, forward_b;
    logic        alu_src_a, alu_src_b, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    mips_bypass_wb #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_wen     (ex_wen),
        .ex_dst     (ex_dst),
        .ex_is_load (ex_is_load),
        .ex_result  (ex_result),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .mem_rdata  (mem_rdata),
        .forward_a  (forward_a),
        .forward_b  (forward_b),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall_cnt  (stall_cnt)
    );

    // In-flight writes: issued one cycle ago (yng) and two cycles ago (old).
    typedef struct {
        bit          vld;
        bit          wen;
        logic [4:0]  dst;
        bit          ld;
        logic [31:0] data;
    } rec_t;

    rec_t        yng, old;
    logic [31:0] exp_cnt;
    bit          exp_stall;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Newest in-flight producer of s wins; a load issued last cycle has no
    // data yet and forces a stall.
    task automatic expect_src(input logic [4:0] s, output logic [31:0] v,
                              output bit use_rf, output bit hz);
        v = 0; use_rf = 1; hz = 0;
        if (s != 0) begin
            if (yng.vld && yng.wen && yng.dst == s) begin
                if (yng.ld) hz = 1;
                else begin v = yng.data; use_rf = 0; end
            end else if (old.vld && old.wen && old.dst == s) begin
                v = old.data; use_rf = 0;
            end
        end
    endtask

    task automatic settle();
        logic [31:0] va, vb;
        bit ra, rb, ha, hb, we;
        @(negedge clk);
        expect_src(ex_rs, va, ra, ha);
        expect_src(ex_rt, vb, rb, hb);
        exp_stall = ha | hb;
        chk("stall", stall, exp_stall);
        if (!ha) begin
            chk("forward_a", forward_a, va);
            chk("alu_src_a", alu_src_a, ra);
        end
        if (!hb) begin
            chk("forward_b", forward_b, vb);
            chk("alu_src_b", alu_src_b, rb);
        end
        chk("stall_cnt", stall_cnt, exp_cnt);
        we = old.vld && old.wen && old.dst != 0;
        chk("rf_we", rf_we, we);
        if (we) begin
            chk("rf_waddr", rf_waddr, old.dst);
            chk("rf_wdata", rf_wdata, old.data);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            yng = '{default: 0};
            old = '{default: 0};
            exp_cnt = 0;
        end else begin
            if (exp_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
            old = yng;
            if (old.ld) old.data = mem_rdata;
            yng = '{vld: ex_valid && !exp_stall, wen: ex_wen, dst: ex_dst,
                    ld: ex_is_load, data: ex_result};
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input logic [4:0] d, input bit l,
                         input logic [31:0] r, input logic [4:0] rs, input logic [4:0] rt);
        ex_valid = v; ex_wen = w; ex_dst = d; ex_is_load = l;
        ex_result = r; ex_rs = rs; ex_rt = rt;
    endtask

    initial begin
        yng = '{default: 0};
        old = '{default: 0};
        exp_cnt = 0;
        exp_stall = 0;
        rst = 1;
        mem_rdata = 0;
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset state
        tick();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_waddr", rf_waddr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_alu_src_a", alu_src_a, 1);
        chk("rst_alu_src_b", alu_src_b, 1);
        chk("rst_forward_a", forward_a, 0);
        chk("rst_forward_b", forward_b, 0);
        settle(); tick();
        rst = 0;

        // EX-EX forwarding, then register-file write two cycles after EX
        drive(1, 1, 5, 0, 32'h1234_5678, 0, 0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 5, 0);
        settle();
        chk("exex_forward_a", forward_a, 32'h1234_5678);
        chk("exex_alu_src_a", alu_src_a, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("wb_rf_we", rf_we, 1);
        chk("wb_rf_waddr", rf_waddr, 5);
        chk("wb_rf_wdata", rf_wdata, 32'h1234_5678);
        tick();

        // M has priority over W
        drive(1, 1, 3, 0, 32'hA, 0, 0);
        settle(); tick();
        drive(1, 1, 3, 0, 32'hB, 0, 0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0, 3);
        settle();
        chk("prio_forward_b", forward_b, 32'hB);
        chk("prio_alu_src_b", alu_src_b, 0);
        tick();

        // load-use: one stall, then forward the load data from W
        drive(1, 1, 7, 1, 32'h0, 0, 0);
        settle(); tick();
        drive(1, 0, 0, 0, 32'h0, 7, 0);
        mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("lu_stall", stall, 1);
        tick();
        mem_rdata = 32'h0;
        settle();
        chk("lu_stall_after", stall, 0);
        chk("lu_forward_a", forward_a, 32'hDEAD_BEEF);
        chk("lu_alu_src_a", alu_src_a, 0);
        chk("lu_stall_cnt", stall_cnt, 1);
        tick();

        // $0 is neither forwarded nor written
        drive(1, 1, 0, 0, 32'h55, 0, 0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("r0_alu_src_a", alu_src_a, 1);
        chk("r0_forward_a", forward_a, 0);
        tick();
        settle();
        chk("r0_rf_we", rf_we, 0);
        tick();

        // reset with both slots full
        drive(1, 1, 9, 0, 32'h99, 0, 0);
        settle(); tick();
        drive(1, 1, 10, 0, 32'h1010, 0, 0);
        settle(); tick();
        drive(0, 0, 0, 0, 0, 9, 10);
        rst = 1;
        settle(); tick();
        rst = 0;
        settle();
        chk("mrst_rf_we", rf_we, 0);
        chk("mrst_alu_src_a", alu_src_a, 1);
        chk("mrst_alu_src_b", alu_src_b, 1);
        chk("mrst_stall_cnt", stall_cnt, 0);
        tick();

        // random stream; a stalled instruction is held by upstream
        for (int i = 0; i < 600; i++) begin
            if (!exp_stall) begin
                drive($urandom_range(3) != 0, $urandom_range(3) != 0,
                      5'($urandom_range(7)), $urandom_range(2) == 0, $urandom,
                      5'($urandom_range(7)), 5'($urandom_range(7)));
            end
            rst = ($urandom_range(99) == 0);
            mem_rdata = $urandom;
            settle(); tick();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
